bcd_display_mux: RTL and testbench
==================================

// Module: bcd_display_mux
// PURPOSE
//  Display-side consumer of the two-digit BCD counter outputs (digit_1, digit_10, carry).
//  Time-multiplexes both digits onto one 7-segment bus with per-digit enables.
//  Snapshots the digits once per scan frame (tear-free), blanks a leading zero,
//  stretches the one-cycle carry pulse into a visible decimal point, flags invalid BCD.
// PARAMETERS
//  REFRESH_DIV    12000  clocks per digit slot (>= DEAD_CYCLES+1)
//  DEAD_CYCLES    16     clocks at slot start with both digits off (anti-ghosting); < REFRESH_DIV
//  FLASH_CYCLES   6000000  clocks dp stays lit after a carry pulse (>= 1)
//  BLANK_LZ       1      1: tens digit dark when its snapshot is 0
//  ACTIVE_LOW     0      1: invert seg and dig_en at the pins (off = all ones)
// PORTS
//  clk       in   1  system clock
//  reset     in   1  synchronous, active-high reset
//  digit_1   in   4  ones digit, BCD
//  digit_10  in   4  tens digit, BCD
//  carry     in   1  one-cycle pulse on 99->00 wrap
//  seg       out  8  {dp,g,f,e,d,c,b,a}, registered
//  dig_en    out  2  one-hot digit enable, [0]=ones [1]=tens, registered
//  err       out  1  snapshot holds a digit > 9, registered
// BEHAVIOUR
//  - Single clock, reset synchronous active-high. On any edge with reset=1: slot counter=0,
//    slot=ones, stretch counter=0, snapshots=0, seg=off, dig_en=00, err=0 (at pins, per ACTIVE_LOW).
//  - Timing (R=REFRESH_DIV, D=DEAD_CYCLES): let k=1,2,.. count edges since reset was last
//    sampled low; p=(k-1) mod R, s=floor((k-1)/R). After edge k: dig_en=00 if p<D, else
//    01 for s even (ones), 10 for s odd (tens). Free-running; period 2R.
//  - States per slot: DEAD (p<D) -> SHOW (p>=D) -> next slot DEAD. seg=off in DEAD.
//  - Snapshot: digit_1/digit_10 captured at edges with p==0, s even (k=1, 2R+1, ...).
//    Displayed values and err use only the snapshot; mid-frame input changes are invisible.
//  - err updates at snapshot edges: 1 iff either snapshot > 9; cleared by next valid snapshot.
//  - Segment code (gfedcba, active-high): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F;
//    10..15: 40 (dash).
//  - Leading zero: BLANK_LZ=1 and tens snapshot==0 -> tens slot keeps dig_en=00, seg=off
//    for the whole slot; ones digit always shown (00 displays "0").
//  - Carry stretch: carry=1 at edge k loads counter with FLASH_CYCLES; stretch active after
//    edges k..k+FLASH_CYCLES-1. A carry while active reloads (retrigger, no accumulation).
//  - dp (seg[7]) = stretch active AND ones slot AND SHOW; never lit in tens slot or DEAD.
//  - Reset mid-slot: same-edge return to reset values; sequence restarts at k=1; stretch dropped.
//  - Counters sized $clog2 of their parameter; no overflow at parameter maxima.
// TESTING  (bench: R=8, D=2, FLASH_CYCLES=20, BLANK_LZ=1, ACTIVE_LOW=0)
//  1 Reset 3 clks, digits 0/0 -> after k=1,2 dig_en=00; k=3..8 dig_en=01 seg=3F;
//    k=9..16 dig_en=00 seg=00 (tens blanked); err=0.
//  2 digit_10=4, digit_1=7 held from reset -> ones slot seg=07 dig_en=01;
//    tens slot (k=11..16) seg=66 dig_en=10.
//  3 digit_1=2, changed to 5 before edge 5 -> seg=5B through k=8; k=17,18 off; seg=6D from k=19.
//  4 carry pulse at edge 40 -> seg[7]=1 only on ones SHOW cycles in k=40..59; pulse again at
//    k=55 -> window extends to k=74; seg[7]=0 on every tens/DEAD cycle.
//  5 digit_1=12 at snapshot k=33 -> err=1 after k=33, seg=40 on ones SHOW; digit_1=3 before
//    k=49 -> err=0 after k=49, seg=4F.
//  6 reset=1 for one edge at k=30 mid-SHOW with stretch active -> dig_en=00, seg=00, err=0;
//    pattern restarts exactly as scenario 1.

Source files
------------

// File: rtl/bcd_display_mux_if.sv
// Bus between a two-digit BCD counter and its multiplexed 7-segment display
// driver.
//   digit_1   ones digit, BCD              (counter -> display)
//   digit_10  tens digit, BCD              (counter -> display)
//   carry     one-cycle 99->00 wrap pulse  (counter -> display)
//   seg       {dp,g,f,e,d,c,b,a}           (display -> pins)
//   dig_en    one-hot digit enable, [0]=ones, [1]=tens
//   err       current snapshot holds a non-BCD digit
interface bcd_display_mux_if;
  logic [3:0] digit_1;
  logic [3:0] digit_10;
  logic       carry;
  logic [7:0] seg;
  logic [1:0] dig_en;
  logic       err;

  modport master (output digit_1, digit_10, carry, input seg, dig_en, err);
  modport slave  (input digit_1, digit_10, carry, output seg, dig_en, err);
endinterface

// File: rtl/bcd_display_mux.sv
// Time-multiplexes a two-digit BCD value onto one 7-segment bus.
// Each digit owns a slot of REFRESH_DIV clocks; the first DEAD_CYCLES clocks
// of every slot drive both digits dark to avoid ghosting. Both digits are
// snapshotted at the start of the ones slot so a frame never tears, a leading
// tens zero can be blanked, and the one-cycle carry pulse is stretched into a
// visible decimal point on the ones digit.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    slave side of bcd_display_mux_if (digits/carry in; seg/dig_en/err out,
//          all outputs registered)
module bcd_display_mux #(
  parameter int REFRESH_DIV  = 12000,
  parameter int DEAD_CYCLES  = 16,
  parameter int FLASH_CYCLES = 6000000,
  parameter bit BLANK_LZ     = 1'b1,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  bcd_display_mux_if.slave   bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FL_W  = $clog2(FLASH_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);
  localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(FLASH_CYCLES);

  localparam logic [7:0] SEG_INV = {8{ACTIVE_LOW}};
  localparam logic [1:0] EN_INV  = {2{ACTIVE_LOW}};

  // Slot and phase of the *upcoming* edge, so the first edge after reset
  // already acts as position 0 of the ones slot.
  typedef enum logic [1:0] {
    ONES_DEAD,
    ONES_SHOW,
    TENS_DEAD,
    TENS_SHOW
  } slot_state_t;

  // With no dead time a slot starts directly in SHOW.
  localparam slot_state_t ONES_FIRST = (DEAD_CYCLES > 0) ? ONES_DEAD : ONES_SHOW;
  localparam slot_state_t TENS_FIRST = (DEAD_CYCLES > 0) ? TENS_DEAD : TENS_SHOW;

  slot_state_t      state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [FL_W-1:0]  flash_q, flash_n;
  logic [3:0]       snap_1_q, snap_10_q;
  logic [3:0]       view_1, view_10;
  logic [7:0]       seg_q, seg_n;
  logic [1:0]       en_q, en_n;
  logic             err_q, err_n;
  logic             is_tens, is_show, snap_now, tens_blank;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h3F;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5B;
      4'd3:    c = 7'h4F;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6D;
      4'd6:    c = 7'h7D;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7F;
      4'd9:    c = 7'h6F;
      default: c = 7'h40; // non-BCD shows a dash
    endcase
    return c;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q + CNT_W'(1);
    seg_n      = 8'h00;
    en_n       = 2'b00;

    is_tens    = (state_q == TENS_DEAD) || (state_q == TENS_SHOW);
    is_show    = (state_q == ONES_SHOW) || (state_q == TENS_SHOW);
    snap_now   = !is_tens && (cnt_q == '0);

    // On a snapshot edge the display uses the value being captured.
    view_1     = snap_now ? bus.digit_1  : snap_1_q;
    view_10    = snap_now ? bus.digit_10 : snap_10_q;
    err_n      = snap_now ? ((bus.digit_1 > 4'd9) || (bus.digit_10 > 4'd9)) : err_q;
    tens_blank = BLANK_LZ && (view_10 == 4'd0);

    // Retrigger reloads rather than accumulates.
    if (bus.carry)          flash_n = FL_LOAD;
    else if (flash_q != '0) flash_n = flash_q - FL_W'(1);
    else                    flash_n = '0;

    if (cnt_q == CNT_LAST) begin
      cnt_n   = '0;
      state_n = is_tens ? ONES_FIRST : TENS_FIRST;
    end else if (cnt_n == DEAD_END) begin
      state_n = is_tens ? TENS_SHOW : ONES_SHOW;
    end

    if (is_show) begin
      if (!is_tens) begin
        en_n  = 2'b01;
        seg_n = {flash_n != '0, seg_code(view_1)};
      end else if (!tens_blank) begin
        en_n  = 2'b10;
        seg_n = {1'b0, seg_code(view_10)};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ONES_FIRST;
      cnt_q     <= '0;
      flash_q   <= '0;
      // NOTE: the snapshots are plain registers (not a memory), so they are
      // reset along with everything else and a fresh frame never shows stale data.
      snap_1_q  <= '0;
      snap_10_q <= '0;
      seg_q     <= SEG_INV;
      en_q      <= EN_INV;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      flash_q   <= flash_n;
      if (snap_now) begin
        snap_1_q  <= bus.digit_1;
        snap_10_q <= bus.digit_10;
      end
      seg_q     <= seg_n ^ SEG_INV;
      en_q      <= en_n ^ EN_INV;
      err_q     <= err_n;
    end
  end

  assign bus.seg    = seg_q;
  assign bus.dig_en = en_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with R=8, D=2, FLASH_CYCLES=20.
// k counts edges since reset was last sampled low; outputs are sampled 1 ns
// after each rising edge and inputs change there too.
module tb_bcd_display_mux;

  logic clk = 1'b0;
  logic reset;
  int   k;
  int   n_assert = 0;
  int   n_fail   = 0;

  bcd_display_mux_if bus ();

  bcd_display_mux #(
    .REFRESH_DIV  (8),
    .DEAD_CYCLES  (2),
    .FLASH_CYCLES (20),
    .BLANK_LZ     (1'b1),
    .ACTIVE_LOW   (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    chk("rst_en",  bus.dig_en, 2'b00);
    chk("rst_seg", bus.seg,    8'h00);
    chk("rst_err", bus.err,    1'b0);
    reset = 1'b0;
    k = 0;
  endtask

  // First frame with digits 0/0: ones shows "0", tens blanked, no dp.
  task automatic frame_zero();
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i >= 3 && i <= 8) begin
        chk("z_en",  bus.dig_en, 2'b01);
        chk("z_seg", bus.seg,    8'h3F);
      end else begin
        chk("z_en",  bus.dig_en, 2'b00);
        chk("z_seg", bus.seg,    8'h00);
      end
      chk("z_err", bus.err, 1'b0);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.digit_1  = 4'd0;
    bus.digit_10 = 4'd0;
    bus.carry    = 1'b0;
    k            = 0;

    // 1: zero display after a 3-clock reset
    do_reset(3);
    frame_zero();

    // 2: 47 held from reset
    bus.digit_1  = 4'd7;
    bus.digit_10 = 4'd4;
    do_reset(1);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i >= 3 && i <= 8) begin
        chk("s2_en",  bus.dig_en, 2'b01);
        chk("s2_seg", bus.seg,    8'h07);
      end else if (i >= 11) begin
        chk("s2_en",  bus.dig_en, 2'b10);
        chk("s2_seg", bus.seg,    8'h66);
      end else begin
        chk("s2_en",  bus.dig_en, 2'b00);
        chk("s2_seg", bus.seg,    8'h00);
      end
    end

    // 3: mid-frame change is invisible until the next snapshot
    bus.digit_1  = 4'd2;
    bus.digit_10 = 4'd0;
    do_reset(1);
    step();                       // k=1 snapshot of 2
    bus.digit_1 = 4'd5;
    repeat (4) step();            // k=5
    chk("s3_seg5", bus.seg, 8'h5B);
    repeat (3) step();            // k=8
    chk("s3_seg8", bus.seg, 8'h5B);
    repeat (2) step();            // k=10
    chk("s3_blank", bus.dig_en, 2'b00);
    repeat (8) step();            // k=18
    chk("s3_dead",  bus.seg, 8'h00);
    step();                       // k=19
    chk("s3_seg19", bus.seg, 8'h6D);
    chk("s3_en19",  bus.dig_en, 2'b01);

    // 5: invalid digit at snapshot k=33, cleared at k=49
    repeat (13) step();           // k=32
    chk("s5_err32", bus.err, 1'b0);
    bus.digit_1 = 4'd12;
    step();                       // k=33
    chk("s5_err33", bus.err, 1'b1);
    repeat (2) step();            // k=35
    chk("s5_dash",  bus.seg, 8'h40);
    chk("s5_en35",  bus.dig_en, 2'b01);
    repeat (5) step();            // k=40
    bus.digit_1 = 4'd3;
    repeat (8) step();            // k=48
    chk("s5_err48", bus.err, 1'b1);
    step();                       // k=49
    chk("s5_err49", bus.err, 1'b0);
    repeat (2) step();            // k=51
    chk("s5_seg51", bus.seg, 8'h4F);

    // 4: carry stretch with retrigger; dp only on ones SHOW cycles
    bus.digit_1  = 4'd0;
    bus.digit_10 = 4'd0;
    do_reset(1);
    for (int i = 1; i <= 88; i++) begin
      bus.carry = (i == 40) || (i == 55);
      step();
      bus.carry = 1'b0;
      chk("s4_dp", bus.seg[7],
          (i == 40) || (i >= 51 && i <= 56) || (i >= 67 && i <= 72));
    end

    // 6: reset mid-SHOW with stretch active and err set
    bus.digit_1  = 4'd0;
    bus.digit_10 = 4'd11;
    do_reset(2);
    for (int i = 1; i <= 29; i++) begin
      bus.carry = (i == 25);
      step();
      bus.carry = 1'b0;
    end
    chk("s6_err29", bus.err, 1'b1);
    chk("s6_seg29", bus.seg, 8'h40);
    chk("s6_en29",  bus.dig_en, 2'b10);
    bus.digit_10 = 4'd0;
    do_reset(1);
    frame_zero();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
